// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared state encoding, digit limit and the BCD wrap-around step for the digit sequencer.
// Pure definitions: no latency, no flow control.
package bcd_digit_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Returns {wrap, next_digit}; out-of-range inputs fold to a legal digit.
    function automatic logic [4:0] bcd_advance(input logic [3:0] digit, input logic up);
        logic [4:0] res;
        if (up) begin
            if (digit >= BCD_MAX) res = {1'b1, 4'd0};
            else                  res = {1'b0, digit + 4'd1};
        end else begin
            if (digit == 4'd0)        res = {1'b1, BCD_MAX};
            else if (digit > BCD_MAX) res = {1'b0, BCD_MAX};
            else                      res = {1'b0, digit - 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_sequencer_tick_prescaler.sv
// Free-running step-rate divider: tick flags the terminal count, count returns to 0 when enabled there.
// tick is combinational from the count register; clear overrides count_en, nothing backpressures it.
module tick_prescaler #(
    parameter int TICK_DIV = 5,
    parameter int PS_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= tick ? '0 : count + PS_W'(1);
        end
    end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// BCD digit source for a one-hot decoder: IDLE/RUN/PAUSE control, load, single-step, carry on wrap.
// All outputs registered (one edge from inputs); no backpressure, lower-priority events are dropped.
module bcd_digit_sequencer
    import bcd_digit_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 5,
    parameter int PS_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       up_down,
    input  logic       step,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       enable,
    output logic [3:0] dec_in,
    output logic       carry,
    output logic       running
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] digit_nxt;
    logic       carry_nxt;
    logic       advance;
    logic       ps_clear;
    logic       ps_count_en;
    logic       tick;
    logic [4:0] adv_res;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (ps_clear),
        .count_en (ps_count_en),
        .tick     (tick)
    );

    assign adv_res = bcd_advance(dec_in, up_down);

    // One event per edge in priority order load > stop > start > step/tick.
    always_comb begin
        state_nxt   = state;
        digit_nxt   = dec_in;
        carry_nxt   = 1'b0;
        advance     = 1'b0;
        ps_clear    = 1'b0;
        ps_count_en = 1'b0;

        if (load) begin
            ps_clear = 1'b1;
            if (load_val <= BCD_MAX) digit_nxt = load_val;
        end else if (stop) begin
            case (state)
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: begin
                    state_nxt = ST_IDLE;
                    digit_nxt = 4'd0;
                end
                default:  state_nxt = ST_IDLE;
            endcase
        end else if (start && (state != ST_RUN)) begin
            state_nxt = ST_RUN;
            ps_clear  = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    ps_count_en = 1'b1;
                    advance     = tick;
                end
                ST_PAUSE: advance   = step;
                ST_IDLE:  advance   = 1'b0;
                default:  state_nxt = ST_IDLE;
            endcase
        end

        if (advance) begin
            carry_nxt = adv_res[4];
            digit_nxt = adv_res[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            dec_in  <= 4'd0;
            carry   <= 1'b0;
            enable  <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            dec_in  <= digit_nxt;
            carry   <= carry_nxt;
            enable  <= (state_nxt != ST_IDLE);
            running <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed bench: a TICK_DIV=3 instance exercises control/priority corners, a TICK_DIV=1 instance the every-cycle rate.
// Outputs are sampled 1 time unit after each rising edge.
module tb_bcd_digit_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       up_down;
    logic       step;
    logic       load;
    logic [3:0] load_val;

    logic       enable,  carry,  running;
    logic [3:0] dec_in;
    logic       enable1, carry1, running1;
    logic [3:0] dec_in1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_digit_sequencer #(.TICK_DIV(3), .PS_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .up_down(up_down),
        .step(step), .load(load), .load_val(load_val),
        .enable(enable), .dec_in(dec_in), .carry(carry), .running(running)
    );

    bcd_digit_sequencer #(.TICK_DIV(1), .PS_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .up_down(up_down),
        .step(step), .load(load), .load_val(load_val),
        .enable(enable1), .dec_in(dec_in1), .carry(carry1), .running(running1)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compares {enable, running, carry, dec_in}.
    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed en/run/cy/dig=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                   tag, obs[6], obs[5], obs[4], obs[3:0], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    function automatic logic [6:0] ex(input logic en, input logic run, input logic cy, input int d);
        return {en, run, cy, 4'(d)};
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; up_down = 1'b1;
        step = 1'b0; load = 1'b0; load_val = 4'd0;
        cyc(1);
        chk("reset", {enable, running, carry, dec_in}, ex(0, 0, 0, 0));
        chk("reset_td1", {enable1, running1, carry1, dec_in1}, ex(0, 0, 0, 0));
        reset = 1'b0;

        // Count up through a full decade with a wrap.
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t1_enter_run", {enable, running, carry, dec_in}, ex(1, 1, 0, 0));
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            chk($sformatf("t1_up_edge%0d", k), {enable, running, carry, dec_in},
                ex(1, 1, (k == 30), (k / 3) % 10));
        end
        stop = 1'b1; cyc(1);
        chk("t1_pause", {enable, running, carry, dec_in}, ex(1, 0, 0, 0));
        cyc(1); stop = 1'b0;
        chk("t1_idle", {enable, running, carry, dec_in}, ex(0, 0, 0, 0));

        // Down-count wrap from 0.
        load_val = 4'd0; load = 1'b1; cyc(1); load = 1'b0;
        chk("t2_load0", {enable, running, carry, dec_in}, ex(0, 0, 0, 0));
        up_down = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        chk("t2_run", {enable, running, carry, dec_in}, ex(1, 1, 0, 0));
        cyc(2);
        chk("t2_hold0", {enable, running, carry, dec_in}, ex(1, 1, 0, 0));
        cyc(1);
        chk("t2_wrap9", {enable, running, carry, dec_in}, ex(1, 1, 1, 9));
        cyc(1);
        chk("t2_carry_drop", {enable, running, carry, dec_in}, ex(1, 1, 0, 9));
        cyc(2);
        chk("t2_down8", {enable, running, carry, dec_in}, ex(1, 1, 0, 8));

        // Pause, manual steps, resume.
        load_val = 4'd4; load = 1'b1; cyc(1); load = 1'b0;
        chk("t3_load4", {enable, running, carry, dec_in}, ex(1, 1, 0, 4));
        up_down = 1'b1; stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t3_pause", {enable, running, carry, dec_in}, ex(1, 0, 0, 4));
        step = 1'b1; cyc(1);
        chk("t3_step5", {enable, running, carry, dec_in}, ex(1, 0, 0, 5));
        cyc(1); step = 1'b0;
        chk("t3_step6", {enable, running, carry, dec_in}, ex(1, 0, 0, 6));
        cyc(1);
        chk("t3_hold6", {enable, running, carry, dec_in}, ex(1, 0, 0, 6));
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t3_resume", {enable, running, carry, dec_in}, ex(1, 1, 0, 6));
        cyc(2);
        chk("t3_still6", {enable, running, carry, dec_in}, ex(1, 1, 0, 6));
        cyc(1);
        chk("t3_adv7", {enable, running, carry, dec_in}, ex(1, 1, 0, 7));

        // Stop on the tick edge suppresses the advance.
        cyc(2);
        chk("t4_pre_tick", {enable, running, carry, dec_in}, ex(1, 1, 0, 7));
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t4_stop_on_tick", {enable, running, carry, dec_in}, ex(1, 0, 0, 7));
        cyc(3);
        chk("t4_pause_hold", {enable, running, carry, dec_in}, ex(1, 0, 0, 7));
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t4_idle_clear", {enable, running, carry, dec_in}, ex(0, 0, 0, 0));
        step = 1'b1; cyc(1); step = 1'b0;
        chk("t4_step_in_idle", {enable, running, carry, dec_in}, ex(0, 0, 0, 0));

        // Legal/illegal loads and load-over-start priority.
        load_val = 4'd3; load = 1'b1; cyc(1);
        chk("t5_load3_idle", {enable, running, carry, dec_in}, ex(0, 0, 0, 3));
        load_val = 4'd12; cyc(1); load = 1'b0;
        chk("t5_load12", {enable, running, carry, dec_in}, ex(0, 0, 0, 3));
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_run", {enable, running, carry, dec_in}, ex(1, 1, 0, 3));
        cyc(1);
        chk("t5_run_hold", {enable, running, carry, dec_in}, ex(1, 1, 0, 3));
        load_val = 4'd7; load = 1'b1; cyc(1); load = 1'b0;
        chk("t5_load7_run", {enable, running, carry, dec_in}, ex(1, 1, 0, 7));
        cyc(2);
        chk("t5_hold7", {enable, running, carry, dec_in}, ex(1, 1, 0, 7));
        cyc(1);
        chk("t5_adv8", {enable, running, carry, dec_in}, ex(1, 1, 0, 8));
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("t5_pause", {enable, running, carry, dec_in}, ex(1, 0, 0, 8));
        start = 1'b1; load = 1'b1; load_val = 4'd2; cyc(1);
        start = 1'b0; load = 1'b0;
        chk("t5_load_beats_start", {enable, running, carry, dec_in}, ex(1, 0, 0, 2));

        // Reset mid-run, then the TICK_DIV=1 instance.
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t6_run", {enable, running, carry, dec_in}, ex(1, 1, 0, 2));
        load_val = 4'd5; load = 1'b1; cyc(1); load = 1'b0;
        chk("t6_at5", {enable, running, carry, dec_in}, ex(1, 1, 0, 5));
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("t6_reset", {enable, running, carry, dec_in}, ex(0, 0, 0, 0));
        chk("t6_reset_td1", {enable1, running1, carry1, dec_in1}, ex(0, 0, 0, 0));
        up_down = 1'b1; start = 1'b1; cyc(1); start = 1'b0;
        chk("t6_run_td3", {enable, running, carry, dec_in}, ex(1, 1, 0, 0));
        chk("t6_run_td1", {enable1, running1, carry1, dec_in1}, ex(1, 1, 0, 0));
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            chk($sformatf("t6_td1_edge%0d", k), {enable1, running1, carry1, dec_in1},
                ex(1, 1, (k == 10), k % 10));
            if (k == 3)
                chk("t6_td3_edge3", {enable, running, carry, dec_in}, ex(1, 1, 0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
